// File: rtl/plane_tile_sequencer.sv
// fifo: generic first-word-fall-through queue, head is valid while count != 0.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: the writer must never push when full, because there is no full/ready output.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          pop;

    assign pop    = rd_vld & rd_rdy;
    assign rd_vld = (cnt != '0);
    assign rd_dat = rd_vld ? mem[rp] : '0;
    assign count  = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_vld) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop)    rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(wr_vld) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wp] <= wr_dat;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(wr_vld && (cnt == CW'(DEPTH))));
endmodule

// plane_tile_sequencer: walks SIZE-aligned tiles over a triangle bbox, realigns plane_eq z tiles with their coordinates.
// Latency: a tile issued in cycle c reaches the output in cycle c+LAT+1, so a handshake gives out_valid after LAT+2 cycles.
// Backpressure: issue stalls unless inflight + FIFO occupancy < DEPTH. out_* holds while out_ready is low.
module plane_tile_sequencer #(
    parameter int SIZE  = 2,
    parameter int LAT   = 3,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tri_valid,
    output logic                     tri_ready,
    input  logic [15:0]              tri_xmin,
    input  logic [15:0]              tri_xmax,
    input  logic [15:0]              tri_ymin,
    input  logic [15:0]              tri_ymax,
    input  logic [17:0]              tri_dzdx,
    input  logic [17:0]              tri_dzdy,
    input  logic [17:0]              tri_c,
    output logic [15:0]              pe_x,
    output logic [15:0]              pe_y,
    output logic [17:0]              pe_dzdx,
    output logic [17:0]              pe_dzdy,
    output logic [17:0]              pe_c,
    input  logic [SIZE*SIZE*18-1:0]  pe_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_x,
    output logic [15:0]              out_y,
    output logic [SIZE*SIZE*18-1:0]  out_z,
    output logic                     out_last,
    output logic                     busy
);
    localparam int          ZW   = SIZE * SIZE * 18;
    localparam int          CW   = $clog2(DEPTH + 1);
    localparam logic [15:0] MASK = ~16'(SIZE - 1);
    localparam logic [16:0] STEP = 17'(SIZE);

    typedef enum logic [1:0] {IDLE, WALK, DRAIN} state_t;

    typedef struct packed {
        logic        vld;
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } stage_t;

    typedef struct packed {
        logic [15:0]   x;
        logic [15:0]   y;
        logic          last;
        logic [ZW-1:0] z;
    } res_t;

    state_t        state, nstate;
    stage_t        sr [1:LAT];
    res_t          wr_dat, head;
    logic [15:0]   ox, xmax_q, ymax_q;
    logic [CW-1:0] inflight, fifo_cnt;
    logic [CW:0]   used;
    logic          accept, degen, credit, x_end, y_end;
    logic          issue, issue_last;

    assign degen  = (tri_xmin > tri_xmax) || (tri_ymin > tri_ymax);
    assign accept = tri_valid & tri_ready;
    assign used   = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign credit = used < (CW + 1)'(DEPTH);
    // 17-bit sums let boxes that touch 0xFFFF terminate without wrapping.
    assign x_end  = ({1'b0, pe_x} + STEP) > {1'b0, xmax_q};
    assign y_end  = ({1'b0, pe_y} + STEP) > {1'b0, ymax_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (accept && !degen) nstate = WALK;
            WALK:    if (issue_last)       nstate = DRAIN;
            DRAIN:   if (inflight == '0)   nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        tri_ready  = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: tri_ready = 1'b1;
            WALK: begin
                issue      = credit;
                issue_last = credit & x_end & y_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_x    <= '0;
            pe_y    <= '0;
            pe_dzdx <= '0;
            pe_dzdy <= '0;
            pe_c    <= '0;
            ox      <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
        end else if (accept && !degen) begin
            pe_x    <= tri_xmin & MASK;
            pe_y    <= tri_ymin & MASK;
            ox      <= tri_xmin & MASK;
            xmax_q  <= tri_xmax;
            ymax_q  <= tri_ymax;
            pe_dzdx <= tri_dzdx;
            pe_dzdy <= tri_dzdy;
            pe_c    <= tri_c;
        end else if (issue && !issue_last) begin
            // The last tile's origin is held through DRAIN so plane_eq keeps a stable input.
            if (x_end) begin
                pe_x <= ox;
                pe_y <= pe_y + 16'(SIZE);
            end else begin
                pe_x <= pe_x + 16'(SIZE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= LAT; k++) sr[k] <= '0;
            inflight <= '0;
        end else begin
            sr[1] <= '{vld: issue, x: pe_x, y: pe_y, last: issue_last};
            for (int k = 2; k <= LAT; k++) sr[k] <= sr[k-1];
            inflight <= inflight + CW'(issue) - CW'(sr[LAT].vld);
        end
    end

    assign wr_dat = {sr[LAT].x, sr[LAT].y, sr[LAT].last, pe_z};

    fifo #(.W($bits(res_t)), .DEPTH(DEPTH)) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (sr[LAT].vld),
        .wr_dat (wr_dat),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head),
        .count  (fifo_cnt)
    );

    assign out_x    = head.x;
    assign out_y    = head.y;
    assign out_z    = head.z;
    assign out_last = head.last;
    assign busy     = (state != IDLE) || out_valid;
endmodule

// File: doc/plane_tile_sequencer.md
# plane_tile_sequencer

Sequencer that drives the `plane_eq` SIZE×SIZE evaluator across a triangle's bounding box. It accepts one triangle setup (bounding box plus dz/dx, dz/dy and c coefficients) per valid/ready handshake. It walks SIZE-aligned tiles in raster order, presenting each tile origin to `plane_eq`, and realigns the returned z tiles with their coordinates. Results go out on a backpressured stream through a credit-controlled output FIFO. It sits between triangle setup and the depth-test/fragment stage of the rasterizer.

## Interface

Parameters:
- SIZE, 2, tile edge in pixels; power of two, matches `plane_eq` SIZE
- LAT, 3, `plane_eq` latency in cycles from x/y change to valid z
- DEPTH, 8, output FIFO entries; DEPTH ≥ LAT+2 gives one tile/cycle

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- tri_valid  in  1  triangle setup valid
- tri_ready  out  1  high only in IDLE
- tri_xmin, tri_xmax, tri_ymin, tri_ymax  in  16 each  inclusive pixel bounding box, unsigned
- tri_dzdx, tri_dzdy, tri_c  in  18 each  plane coefficients, passed through untouched
- pe_x, pe_y  out  16 each  tile origin to `plane_eq`
- pe_dzdx, pe_dzdy, pe_c  out  18 each  coefficients to `plane_eq`, held for the whole triangle
- pe_z  in  SIZE×SIZE×18  z tile from `plane_eq`
- out_valid  out  1  result tile valid
- out_ready  in  1  consumer accepts
- out_x, out_y  out  16 each  tile origin of result
- out_z  out  SIZE×SIZE×18  z tile
- out_last  out  1  final tile of the triangle
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation

- States: IDLE, WALK, DRAIN.
- **IDLE**
  - tri_ready=1.
  - On tri_valid handshake:
    - latch coefficients into pe_* registers.
    - Tile origin: ox = xmin & ~(SIZE-1), oy = ymin & ~(SIZE-1). Load pe_x=ox, pe_y=oy.
    - Go to WALK.
  - Degenerate box (xmin>xmax or ymin>ymax): accept, emit no tiles, stay IDLE.
- **WALK**
  - Each cycle with credit (inflight + fifo_count < DEPTH, registered counts, no same-cycle pop bypass), the current pe_x/pe_y is issued.
  - On the issue edge, advance:
    - pe_x += SIZE.
    - If pe_x+SIZE > xmax, then pe_x = ox and pe_y += SIZE.
  - The tile with pe_x+SIZE > xmax and pe_y+SIZE > ymax is issued with last=1, then go to DRAIN.
  - Comparisons use 17-bit sums, so boxes touching 0xFFFF terminate without wrap.
- **DRAIN**
  - Wait until inflight = 0, then go to IDLE.
  - pe_* stays stable until then; FIFO contents may remain.
- Alignment: shift registers of LAT stages carry {issue, x, y, last}. When stage LAT is set, {x, y, last, pe_z} is written into the FIFO.
- Output: FIFO head drives out_*. Pop on out_valid & out_ready.
- FIFO overflow is impossible by credit; a write to a full FIFO is a design error (assertion).

## Timing

- Reset (rst=0, async): state=IDLE, FIFO and shift registers cleared, inflight=0.
  - All outputs 0 except tri_ready=1.
  - Mid-walk reset discards all in-flight and buffered tiles.
- Handshake cycle T: pe_x/pe_y/pe_dzdx/pe_dzdy/pe_c valid from T+1; first issue at T+1 if credit.
- An issue at cycle c writes the FIFO at the end of c+LAT. out_valid is earliest at c+LAT+1.
- Minimum tri handshake → out_valid: LAT+2 cycles.
- With DEPTH ≥ LAT+2 and out_ready=1: one tile issued per cycle, no bubbles.
- out_* is stable while out_valid=1 and out_ready=0.
- Next tri_ready: the cycle after DRAIN sees inflight=0.
- Tiles of consecutive triangles stay in order.

## Test plan

- Single tile: box (0,0)-(1,1), SIZE=2, LAT=3, dzdx=0x0F800, dzdy=0x07800, c=0, out_ready=1.
  - Expect one tile, out_x=0, out_y=0, out_last=1.
  - out_valid exactly 5 cycles after the handshake.
  - out_z equals the golden plane_eq model.
- Raster walk: box (3,1)-(8,4).
  - Expect origins (2,0),(4,0),(6,0),(8,0),(2,2),(4,2),(6,2),(8,2),(2,4),(4,4),(6,4),(8,4), in that order.
  - Issued on consecutive cycles; out_last only on (8,4).
- Backpressure: same box, out_ready=0 for 20 cycles, then 1.
  - pe_x stalls once 8 credits are used.
  - No tile lost or duplicated.
  - out_* held stable while stalled.
  - tri_ready stays 0 until DRAIN completes.
- Degenerate box: xmin=5, xmax=4.
  - Accepted in one cycle, no out_valid, tri_ready back to 1 the next cycle.
- Edge of range: box (0xFFFC,0xFFFE)-(0xFFFF,0xFFFF).
  - Expect tiles (0xFFFC,0xFFFE) and (0xFFFE,0xFFFE), the second with out_last=1; terminates with no wrap.
- Reset mid-walk: assert rst during tile 5 of the raster walk.
  - All outputs 0, tri_ready=1 asynchronously.
  - After release, a new single-tile triangle completes normally.
